accum_ram: RTL

Single-port, parametrised scratch memory for the parallel adder accumulator. Each word is split into independent lanes. Requests can read a word, write it under a lane mask, or accumulate into it in place: a lane-wise read-modify-write done in the memory's own two-stage pipeline. A sweep FSM zeroes the whole array after reset or on command. It supersedes the plain synchronous RAM as the accumulator's result store.

---
 rtl/accum_ram.sv | 127 ++++++++++++
 1 files changed

// File: rtl/accum_ram.sv
// rtl/accum_ram.sv - lane-wise read/write/accumulate scratch memory with clear sweep
// Two-stage pipeline; S2 result is forwarded so same-address requests stay coherent.
module accum_ram #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 512,
   parameter int LANE_WIDTH = 32,
   parameter int SATURATE   = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               req_valid,
   input  logic [1:0]                         op,
   input  logic [ADDR_WIDTH-1:0]              addr,
   input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   lane_en,
   input  logic [DATA_WIDTH-1:0]              data_in,
   output logic                               busy,
   output logic                               out_valid,
   output logic [DATA_WIDTH-1:0]              data_out
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int LANES = DATA_WIDTH / LANE_WIDTH;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_ACC   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [0:0] {IDLE, CLEAR} state_t;

   state_t                  state;
   state_t                  state_next;
   logic [ADDR_WIDTH-1:0]   cnt;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    s1_valid;
   logic [1:0]              s1_op;
   logic [ADDR_WIDTH-1:0]   s1_addr;
   logic [LANES-1:0]        s1_lane_en;
   logic [DATA_WIDTH-1:0]   s1_data;
   logic [DATA_WIDTH-1:0]   s1_word;
   logic [DATA_WIDTH-1:0]   result;
   logic                    s1_writes;
   logic                    s1_reports;
   logic                    accept;
   logic                    clear_req;

   function automatic logic [LANE_WIDTH-1:0] lane_add(input logic [LANE_WIDTH-1:0] a,
                                                      input logic [LANE_WIDTH-1:0] b);
      logic [LANE_WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (SATURATE != 0 && sum[LANE_WIDTH])
         return '1;
      return sum[LANE_WIDTH-1:0];
   endfunction

   assign busy       = (state == CLEAR);
   assign accept     = req_valid && !busy;
   assign clear_req  = accept && (op == OP_CLEAR);
   assign s1_writes  = s1_valid && (s1_op == OP_WRITE || s1_op == OP_ACC);
   assign s1_reports = s1_valid && (s1_op == OP_READ || s1_op == OP_ACC);

   always_comb begin
      result = s1_word;
      for (int i = 0; i < LANES; i++) begin
         if (s1_lane_en[i]) begin
            if (s1_op == OP_WRITE)
               result[i*LANE_WIDTH +: LANE_WIDTH] = s1_data[i*LANE_WIDTH +: LANE_WIDTH];
            else if (s1_op == OP_ACC)
               result[i*LANE_WIDTH +: LANE_WIDTH] =
                  lane_add(s1_word[i*LANE_WIDTH +: LANE_WIDTH], s1_data[i*LANE_WIDTH +: LANE_WIDTH]);
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (clear_req) state_next = CLEAR;
         CLEAR:   if (&cnt) state_next = IDLE;
         default: state_next = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (state == CLEAR)
            cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         data_out  <= '0;
      end else begin
         s1_valid  <= accept && (op != OP_CLEAR);
         out_valid <= s1_reports;
         if (s1_reports)
            data_out <= result;
      end
   end

   // The word being written this edge is not yet in mem, so take it from the S2 result.
   always_ff @(posedge clk) begin
      s1_op      <= op;
      s1_addr    <= addr;
      s1_lane_en <= lane_en;
      s1_data    <= data_in;
      s1_word    <= (s1_writes && s1_addr == addr) ? result : mem[addr];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR)
            mem[cnt] <= '0;
         else if (s1_writes)
            mem[s1_addr] <= result;
      end
   end

endmodule
